// File: rtl/sound_timer_if.sv
// CPU/video-side signal bundle for the CHIP-8 style delay/sound timer block.
// The master side drives the frame sync and load strobes; the slave side is the timer.
interface sound_timer_if;
  localparam int unsigned DATA_W = 8;

  logic              vsync;
  logic              dt_we;
  logic [DATA_W-1:0] dt_din;
  logic              st_we;
  logic [DATA_W-1:0] st_din;
  logic [DATA_W-1:0] dt_dout;
  logic              beep;
  logic              spkr;

  modport master (
    output vsync, dt_we, dt_din, st_we, st_din,
    input  dt_dout, beep, spkr
  );

  modport slave (
    input  vsync, dt_we, dt_din, st_we, st_din,
    output dt_dout, beep, spkr
  );
endinterface

// File: rtl/sound_timer.sv
// 60 Hz delay and sound timers decremented on vsync rising edges, with a
// square-wave tone generator that runs while the sound timer is nonzero.
module sound_timer #(
  parameter int unsigned TONE_HALF = 6000
) (
  input  logic         clk,
  input  logic         reset,
  sound_timer_if.slave bus
);
  localparam int unsigned TMR_W  = 8;
  localparam int unsigned CNT_W  = 16;
  localparam logic [CNT_W-1:0] TCNT_LAST = CNT_W'(TONE_HALF - 1);

  logic             vsync_q, vsync_d;
  logic [TMR_W-1:0] dt_q, dt_d;
  logic [TMR_W-1:0] st_q, st_d;
  logic [CNT_W-1:0] tcnt_q, tcnt_d;
  logic             phase_q, phase_d;
  logic             tick_c;
  logic             beep_c;

  // vsync_q resets high so a vsync already high at reset release is not an edge
  always_ff @(posedge clk) begin
    if (!reset) begin
      vsync_q <= 1'b1;
      dt_q    <= '0;
      st_q    <= '0;
      tcnt_q  <= '0;
      phase_q <= 1'b0;
    end else begin
      vsync_q <= vsync_d;
      dt_q    <= dt_d;
      st_q    <= st_d;
      tcnt_q  <= tcnt_d;
      phase_q <= phase_d;
    end
  end

  assign tick_c = bus.vsync & ~vsync_q;
  assign beep_c = (st_q != '0);

  // Timer update: a CPU load wins over the tick; decrement saturates at zero
  always_comb begin
    vsync_d = bus.vsync;
    dt_d    = dt_q;
    st_d    = st_q;
    if (bus.dt_we) begin
      dt_d = bus.dt_din;
    end else if (tick_c && (dt_q != '0)) begin
      dt_d = dt_q - TMR_W'(1);
    end
    if (bus.st_we) begin
      st_d = bus.st_din;
    end else if (tick_c && (st_q != '0)) begin
      st_d = st_q - TMR_W'(1);
    end
  end

  // Tone divider keeps running across nonzero reloads so the waveform never glitches
  always_comb begin
    tcnt_d  = '0;
    phase_d = 1'b0;
    if (beep_c) begin
      if (tcnt_q == TCNT_LAST) begin
        tcnt_d  = '0;
        phase_d = ~phase_q;
      end else begin
        tcnt_d  = tcnt_q + CNT_W'(1);
        phase_d = phase_q;
      end
    end
  end

  assign bus.dt_dout = dt_q;
  assign bus.beep    = beep_c;
  assign bus.spkr    = phase_q & beep_c;
endmodule

// File: tb/tb_sound_timer.sv
// Self-checking bench for sound_timer: directed vector table, hand-written
// tone/reset/mute sequences and randomized traffic against a cycle model.
module tb_sound_timer;
  localparam int unsigned TH = 4;

  logic clk = 1'b0;
  logic reset;

  sound_timer_if u_if ();
  sound_timer_if u_if1 ();

  sound_timer #(.TONE_HALF(TH)) u_dut  (.clk(clk), .reset(reset), .bus(u_if.slave));
  sound_timer #(.TONE_HALF(1))  u_dut1 (.clk(clk), .reset(reset), .bus(u_if1.slave));

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: timer values plus number of cycles the tone has been sounding
  int m_dt, m_st, m_n;
  bit m_vsq;

  typedef struct {
    string name;
    bit    r, vs, dwe;
    int    ddin;
    bit    swe;
    int    sdin;
    int    e_dt, e_bp, e_sp;
  } vec_t;
  vec_t vecs[$];

  function automatic vec_t mk(string name, bit r, bit vs, bit dwe, int ddin, bit swe, int sdin,
                              int e_dt, int e_bp, int e_sp);
    vec_t v;
    v.name = name; v.r = r; v.vs = vs; v.dwe = dwe; v.ddin = ddin; v.swe = swe; v.sdin = sdin;
    v.e_dt = e_dt; v.e_bp = e_bp; v.e_sp = e_sp;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, advance the model at the edge, return at the next negedge
  task automatic step(input bit r, input bit vs, input bit dwe, input int ddin,
                      input bit swe, input int sdin);
    bit sounding, tick;
    reset       = r;
    u_if.vsync  = vs;
    u_if.dt_we  = dwe;
    u_if.dt_din = 8'(ddin);
    u_if.st_we  = swe;
    u_if.st_din = 8'(sdin);
    @(posedge clk);
    sounding = (m_st != 0);
    if (!r) begin
      m_dt = 0; m_st = 0; m_n = 0; m_vsq = 1'b1;
    end else begin
      tick  = vs && !m_vsq;
      m_vsq = vs;
      if (dwe) m_dt = ddin & 255;
      else if (tick && m_dt > 0) m_dt = m_dt - 1;
      if (swe) m_st = sdin & 255;
      else if (tick && m_st > 0) m_st = m_st - 1;
      m_n = sounding ? m_n + 1 : 0;
    end
    @(negedge clk);
  endtask

  task automatic idle(input bit vs, input int k);
    for (int i = 0; i < k; i++) step(1'b1, vs, 1'b0, 0, 1'b0, 0);
  endtask

  task automatic expect_out(input string name, input int dt, input int bp, input int sp);
    chk({name, " dt_dout"}, int'(u_if.dt_dout), dt);
    chk({name, " beep"},    int'(u_if.beep),    bp);
    chk({name, " spkr"},    int'(u_if.spkr),    sp);
  endtask

  task automatic chk_model(input string name);
    int e_sp;
    e_sp = (m_st != 0 && ((m_n / int'(TH)) % 2) == 1) ? 1 : 0;
    expect_out(name, m_dt, (m_st != 0) ? 1 : 0, e_sp);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int cnt, e_sp;
    u_if1.vsync = 1'b0; u_if1.dt_we = 1'b0; u_if1.dt_din = 8'd0;
    u_if1.st_we = 1'b0; u_if1.st_din = 8'd0;
    m_dt = 0; m_st = 0; m_n = 0; m_vsq = 1'b1;

    // Directed table: load/decrement with saturation, held vsync, load-vs-tick priority
    vecs.push_back(mk("reset",         0, 0, 0, 0,  0, 0, 0,  0, 0));
    vecs.push_back(mk("dt load 3",     1, 0, 1, 3,  0, 0, 3,  0, 0));
    vecs.push_back(mk("tick 1",        1, 1, 0, 0,  0, 0, 2,  0, 0));
    vecs.push_back(mk("vsync held",    1, 1, 0, 0,  0, 0, 2,  0, 0));
    vecs.push_back(mk("vsync low",     1, 0, 0, 0,  0, 0, 2,  0, 0));
    vecs.push_back(mk("tick 2",        1, 1, 0, 0,  0, 0, 1,  0, 0));
    vecs.push_back(mk("vsync low 2",   1, 0, 0, 0,  0, 0, 1,  0, 0));
    vecs.push_back(mk("tick 3",        1, 1, 0, 0,  0, 0, 0,  0, 0));
    vecs.push_back(mk("vsync low 3",   1, 0, 0, 0,  0, 0, 0,  0, 0));
    vecs.push_back(mk("tick 4 sat",    1, 1, 0, 0,  0, 0, 0,  0, 0));
    vecs.push_back(mk("load dt st",    1, 0, 1, 10, 1, 5, 10, 1, 0));
    vecs.push_back(mk("st load+tick",  1, 1, 0, 0,  1, 9, 9,  1, 0));
    foreach (vecs[i]) begin
      step(vecs[i].r, vecs[i].vs, vecs[i].dwe, vecs[i].ddin, vecs[i].swe, vecs[i].sdin);
      expect_out(vecs[i].name, vecs[i].e_dt, vecs[i].e_bp, vecs[i].e_sp);
    end

    // st must be 9 after the load/tick collision: sounding through 8 more ticks, silent after 9
    for (int k = 0; k < 8; k++) begin
      step(1'b1, 1'b0, 1'b0, 0, 1'b0, 0);
      step(1'b1, 1'b1, 1'b0, 0, 1'b0, 0);
    end
    chk("prio 8 ticks dt", int'(u_if.dt_dout), 1);
    chk("prio 8 ticks beep", int'(u_if.beep), 1);
    step(1'b1, 1'b0, 1'b0, 0, 1'b0, 0);
    step(1'b1, 1'b1, 1'b0, 0, 1'b0, 0);
    expect_out("prio 9 ticks", 0, 0, 0);

    // vsync high through reset release must not tick
    step(1'b0, 1'b1, 1'b1, 8'h55, 1'b1, 7);
    expect_out("reset prio", 0, 0, 0);
    step(1'b1, 1'b1, 1'b0, 0, 1'b0, 0);
    expect_out("release vsync high", 0, 0, 0);
    step(1'b1, 1'b1, 1'b1, 5, 1'b0, 0);
    idle(1'b1, 6);
    expect_out("vsync held after reset", 5, 0, 0);

    // Tone: st=2, 4 low / 4 high, silent one cycle after 2nd vsync edge
    step(1'b1, 1'b0, 1'b0, 0, 1'b0, 0);
    step(1'b1, 1'b0, 1'b0, 0, 1'b1, 2);
    expect_out("tone start", 5, 1, 0);
    for (int n = 1; n < 16; n++) begin
      idle(1'b0, 1);
      e_sp = ((n >= 4 && n < 8) || n >= 12) ? 1 : 0;
      chk($sformatf("tone wave n=%0d", n), int'(u_if.spkr), e_sp);
    end
    step(1'b1, 1'b1, 1'b0, 0, 1'b0, 0);
    chk("tone after tick 1 beep", int'(u_if.beep), 1);
    step(1'b1, 1'b0, 1'b0, 0, 1'b0, 0);
    step(1'b1, 1'b1, 1'b0, 0, 1'b0, 0);
    expect_out("tone after tick 2", 3, 0, 0);

    // Nonzero reload mid-tone keeps the waveform phase
    step(1'b1, 1'b0, 1'b0, 0, 1'b1, 30);
    idle(1'b0, 5);
    chk("pre-reload spkr", int'(u_if.spkr), 1);
    step(1'b1, 1'b0, 1'b0, 0, 1'b1, 7);
    expect_out("reload n=6", 3, 1, 1);
    for (int n = 7; n <= 12; n++) begin
      idle(1'b0, 1);
      e_sp = (n < 8 || n >= 12) ? 1 : 0;
      chk($sformatf("reload wave n=%0d", n), int'(u_if.spkr), e_sp);
    end

    // Reset in the middle of a high spkr phase
    step(1'b0, 1'b0, 1'b0, 0, 1'b0, 0);
    expect_out("reset mid-tone", 0, 0, 0);

    // Mute then restart: first rise exactly TH cycles after beep
    step(1'b1, 1'b0, 1'b0, 0, 1'b1, 20);
    idle(1'b0, 5);
    step(1'b1, 1'b0, 1'b0, 0, 1'b1, 0);
    expect_out("mute", 0, 0, 0);
    step(1'b1, 1'b0, 1'b0, 0, 1'b1, 3);
    expect_out("restart", 0, 1, 0);
    cnt = 0;
    while (u_if.spkr !== 1'b1 && cnt < 20) begin
      idle(1'b0, 1);
      cnt++;
    end
    chk("restart first rise", cnt, int'(TH));

    // TONE_HALF = 1 toggles every cycle
    u_if1.st_we = 1'b1; u_if1.st_din = 8'd3;
    idle(1'b0, 1);
    u_if1.st_we = 1'b0;
    chk("th1 beep", int'(u_if1.beep), 1);
    chk("th1 spkr n=0", int'(u_if1.spkr), 0);
    for (int n = 1; n <= 6; n++) begin
      idle(1'b0, 1);
      chk($sformatf("th1 spkr n=%0d", n), int'(u_if1.spkr), n % 2);
    end

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      bit r, vs, dwe, swe;
      int ddin, sdin;
      r    = ($urandom_range(0, 499) != 0);
      vs   = ($urandom_range(0, 15) == 0) ? ~u_if.vsync : u_if.vsync;
      dwe  = ($urandom_range(0, 39) == 0);
      swe  = ($urandom_range(0, 39) == 0);
      ddin = int'($urandom_range(0, 255));
      sdin = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 255));
      step(r, vs, dwe, ddin, swe, sdin);
      chk_model($sformatf("rand %0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/sound_timer.md
SOUND_TIMER -- requirements
Module: sound_timer

Interface
REQ-001: Parameter TONE_HALF, default 6000, meaning the number of clk cycles per speaker half-period; the legal range is 1..65535.
REQ-002: clk  input  1  system clock; all state updates on the rising edge.
REQ-003: reset  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-004: vsync  input  1  frame sync from the hvsync generator, asynchronous to frame content; its rising edge is the 60 Hz timer tick.
REQ-005: dt_we  input  1  delay-timer load strobe, one cycle, from the cpu.
REQ-006: dt_din  input  8  delay-timer load value.
REQ-007: st_we  input  1  sound-timer load strobe, one cycle, from the cpu.
REQ-008: st_din  input  8  sound-timer load value.
REQ-009: dt_dout  output  8  current delay-timer value, a direct register output.
REQ-010: beep  output  1  high while the sound timer is nonzero.
REQ-011: spkr  output  1  square-wave speaker drive, gated by beep.

Function
REQ-012: The block SHALL register vsync into vsync_q every cycle, and tick = vsync & ~vsync_q, so that exactly one tick occurs per vsync rising edge.
REQ-013: Registers SHALL be dt[7:0] and st[7:0], both unsigned.
REQ-014: On tick, each timer SHALL decrement by 1 if it is nonzero and hold at 0 otherwise; there is no wrap to 255.
REQ-015: When dt_we is high, dt SHALL load dt_din on that edge regardless of tick; a load takes priority and no decrement is applied in that cycle. The same rule applies to st_we/st_din.
REQ-016: dt and st SHALL be fully independent, so simultaneous dt_we, st_we and tick are all honoured per REQ-014/015.
REQ-017: The loaded value SHALL be visible on dt_dout, and reflected in beep, in the cycle after the strobe edge (1-cycle latency).
REQ-018: beep SHALL equal (st != 0), decoded combinationally from the st register with no additional latency.
REQ-019: Tone generator: a 16-bit counter tcnt and a phase bit.
  - beep = 0: tcnt <= 0, phase <= 0.
  - beep = 1 and tcnt == TONE_HALF-1: tcnt <= 0, phase <= ~phase.
  - beep = 1 otherwise: tcnt <= tcnt + 1.
REQ-020: spkr SHALL equal phase & beep, so it is low in every cycle in which st == 0.
REQ-021: The first spkr rising edge SHALL occur TONE_HALF cycles after beep first goes high; the period thereafter is 2*TONE_HALF cycles with a 50% duty cycle.
REQ-022: A reload of st while it is already nonzero SHALL NOT reset tcnt or phase, so the tone continues without a glitch.
REQ-023: Loading st with 0 SHALL stop the tone on the next edge, forcing tcnt = 0 and phase = 0.
REQ-024: With TONE_HALF = 1, phase SHALL toggle every cycle while beep is high.
REQ-025: A vsync level held high or low for any length of time SHALL generate no additional ticks.

Reset
REQ-026: While reset = 0 at a clk edge, the block SHALL set dt = 0, st = 0, tcnt = 0, phase = 0 and vsync_q = 1.
REQ-027: Because vsync_q resets to 1, vsync already high at reset release SHALL produce no spurious tick.
REQ-028: Reset SHALL take priority over dt_we, st_we and tick in the same cycle.
REQ-029: A reset asserted mid-tone SHALL drive beep = 0 and spkr = 0 in the cycle after the reset edge.
REQ-030: Output values after reset: dt_dout = 0, beep = 0, spkr = 0.

Verification
REQ-031: Load/decrement: dt_we with dt_din = 3, then 4 vsync pulses -> dt_dout reads 3, 2, 1, 0, 0 (holds at 0, never 255).
REQ-032: Tone: TONE_HALF = 4, st_we with st_din = 2 -> beep = 1 on the next cycle; spkr low for 4 cycles, then alternates 4 high / 4 low; after the 2nd vsync rising edge, beep = 0 and spkr = 0 on the following cycle.
REQ-033: Priority: st = 5, with st_we (st_din = 9) in the same cycle as a tick -> st = 9, not 8 and not 4; dt decrements normally in that cycle.
REQ-034: Glitch-free reload: TONE_HALF = 4, mid-tone st_we with st_din = 7 -> the spkr waveform continues unbroken; tcnt is not cleared.
REQ-035: Reset: vsync held high through reset deassertion -> no tick is generated and dt remains 0. Separately, reset pulsed during an active tone -> beep = 0, spkr = 0 and dt_dout = 0 on the cycle after the reset edge.
REQ-036: Mute: st_we with st_din = 0 during an active tone -> spkr = 0 and beep = 0 on the next cycle; a following beep restart produces its first spkr rise after exactly TONE_HALF cycles.
